// File: rtl/sc_phase_gen.sv
// Two-phase non-overlapping clock generator for the switched-capacitor stage.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped, both phases low, waiting for en
// PH1   | phase 1 high (unless the cycle is skipped), lasts W clocks
// DEAD1 | both phases low, lasts D clocks
// PH2   | phase 2 high (unless the cycle is skipped), lasts W clocks
// DEAD2 | both phases low, lasts D clocks; en decides restart or stop
//
// W/D/S are shadowed at each cycle start, so mid-cycle configuration
// changes only take effect on the next cycle. phi1/phi2 are registered
// from the next-state decode, which makes them glitch-free and lets the
// async reset pull them low without waiting for a clock edge.
module sc_phase_gen #(
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             skip,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] dead,
    output logic             phi1,
    output logic             phi2,
    output logic             active,
    output logic             cycle_done,
    output logic [CYC_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PH1   = 3'd1,
        DEAD1 = 3'd2,
        PH2   = 3'd3,
        DEAD2 = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] w_sh, d_sh;
    logic             s_sh;
    logic             latch;
    logic             s_nxt;
    logic [CNT_W-1:0] w_in, d_in;

    // Zero-length phases would break the non-overlap guarantee, so clamp to 1.
    assign w_in = (width == '0) ? CNT_W'(1) : width;
    assign d_in = (dead == '0) ? CNT_W'(1) : dead;

    // Next-state and phase-counter decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        latch      = 1'b0;
        cycle_done = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = PH1;
                    latch     = 1'b1;
                    cnt_nxt   = w_in - CNT_W'(1);
                end
            end
            PH1: begin
                if (cnt == '0) begin
                    state_nxt = DEAD1;
                    cnt_nxt   = d_sh - CNT_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DEAD1: begin
                if (cnt == '0) begin
                    state_nxt = PH2;
                    cnt_nxt   = w_sh - CNT_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            PH2: begin
                if (cnt == '0) begin
                    state_nxt = DEAD2;
                    cnt_nxt   = d_sh - CNT_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DEAD2: begin
                if (cnt == '0) begin
                    cycle_done = 1'b1;
                    if (en) begin
                        state_nxt = PH1;
                        latch     = 1'b1;
                        cnt_nxt   = w_in - CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign s_nxt  = latch ? skip : s_sh;
    assign active = (state != IDLE);

    // State, counter, shadow configuration and registered phase outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            w_sh    <= '0;
            d_sh    <= '0;
            s_sh    <= 1'b0;
            phi1    <= 1'b0;
            phi2    <= 1'b0;
            cyc_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                w_sh <= w_in;
                d_sh <= d_in;
                s_sh <= skip;
            end
            phi1 <= (state_nxt == PH1) & ~s_nxt;
            phi2 <= (state_nxt == PH2) & ~s_nxt;
            if (cycle_done) begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sc_phase_gen.sv
// Directed bench for sc_phase_gen: per-clock phase patterns against
// hand-computed bit vectors (bit i = i-th sampled clock).
module tb_sc_phase_gen;

    localparam int CNT_W = 8;
    localparam int CYC_W = 16;

    logic             clk;
    logic             rstn;
    logic             en;
    logic             skip;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] dead;
    logic             phi1;
    logic             phi2;
    logic             active;
    logic             cycle_done;
    logic [CYC_W-1:0] cyc_cnt;

    int total = 0;
    int bad   = 0;

    sc_phase_gen #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .skip       (skip),
        .width      (width),
        .dead       (dead),
        .phi1       (phi1),
        .phi2       (phi2),
        .active     (active),
        .cycle_done (cycle_done),
        .cyc_cnt    (cyc_cnt)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n clocks, sampling 1 ns after each edge against the patterns.
    task automatic run_seq(input string tag, input logic [31:0] p1, input logic [31:0] p2,
                           input logic [31:0] dn, input int n);
        logic prev1, prev2;
        prev1 = phi1;
        prev2 = phi2;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".phi1"}, 32'(phi1), 32'(p1[i]));
            chk({tag, ".phi2"}, 32'(phi2), 32'(p2[i]));
            chk({tag, ".done"}, 32'(cycle_done), 32'(dn[i]));
            chk({tag, ".ovl"}, 32'(phi1 & phi2), 32'd0);
            chk({tag, ".adj"}, 32'((prev1 & phi2) | (prev2 & phi1)), 32'd0);
            prev1 = phi1;
            prev2 = phi2;
        end
    endtask

    initial begin
        rstn  = 1'b0;
        en    = 1'b0;
        skip  = 1'b0;
        width = 8'd3;
        dead  = 8'd1;

        // Reset state.
        #12;
        chk("rst.phi1", 32'(phi1), 32'd0);
        chk("rst.phi2", 32'(phi2), 32'd0);
        chk("rst.active", 32'(active), 32'd0);
        chk("rst.done", 32'(cycle_done), 32'd0);
        chk("rst.cyc", 32'(cyc_cnt), 32'd0);
        rstn = 1'b1;
        run_seq("idle", 32'h0, 32'h0, 32'h0, 2);
        chk("idle.active", 32'(active), 32'd0);

        // Basic W=3 D=1, four full periods of 8 clocks.
        en = 1'b1;
        run_seq("basic", 32'h07070707, 32'h70707070, 32'h80808080, 32);
        run_seq("basic.wrap", 32'h1, 32'h0, 32'h0, 1);
        chk("basic.cyc", 32'(cyc_cnt), 32'd4);
        chk("basic.active", 32'(active), 32'd1);

        // Stop: en dropped in PH1, rest of the cycle still runs full length.
        en = 1'b0;
        run_seq("stop", 32'h03, 32'h38, 32'h40, 7);
        chk("stop.active_last", 32'(active), 32'd1);
        run_seq("stop.idle", 32'h0, 32'h0, 32'h0, 3);
        chk("stop.active", 32'(active), 32'd0);
        chk("stop.cyc", 32'(cyc_cnt), 32'd5);

        // Clamp: zero width/dead behave as 1/1, period 4.
        width = 8'd0;
        dead  = 8'd0;
        en    = 1'b1;
        run_seq("clamp", 32'h111, 32'h444, 32'h888, 12);
        en = 1'b0;
        run_seq("clamp.stop", 32'h0, 32'h0, 32'h0, 1);
        chk("clamp.active", 32'(active), 32'd0);
        chk("clamp.cyc", 32'(cyc_cnt), 32'd8);

        // Mid-cycle change during PH2: current cycle stays 3/1.
        width = 8'd3;
        dead  = 8'd1;
        en    = 1'b1;
        run_seq("mid.a", 32'h7, 32'h0, 32'h0, 4);
        run_seq("mid.b", 32'h0, 32'h1, 32'h0, 1);
        width = 8'd5;
        dead  = 8'd2;
        run_seq("mid.c", 32'h0, 32'h3, 32'h4, 3);

        // Next cycle runs 5/2 (period 14); en glitch mid-cycle is ignored.
        run_seq("new.a", 32'h7, 32'h0, 32'h0, 3);
        en = 1'b0;
        run_seq("new.b", 32'h3, 32'h0, 32'h0, 3);
        en = 1'b1;
        run_seq("new.c", 32'h0, 32'h3E, 32'h80, 8);
        chk("new.cyc", 32'(cyc_cnt), 32'd9);

        // Skip one cycle: phases held low for the whole 14-clock window.
        skip = 1'b1;
        run_seq("skip.a", 32'h0, 32'h0, 32'h0, 1);
        skip = 1'b0;
        chk("skip.active", 32'(active), 32'd1);
        chk("skip.cyc0", 32'(cyc_cnt), 32'd10);
        run_seq("skip.b", 32'h0, 32'h0, 32'h1000, 13);

        // Cycle after the skip runs normally.
        run_seq("post", 32'h001F, 32'h0F80, 32'h2000, 14);
        run_seq("post.next", 32'h3, 32'h0, 32'h0, 2);
        chk("post.cyc", 32'(cyc_cnt), 32'd12);

        // Async reset between edges while phi1 is high.
        #3;
        rstn = 1'b0;
        #1;
        chk("arst.phi1", 32'(phi1), 32'd0);
        chk("arst.phi2", 32'(phi2), 32'd0);
        chk("arst.active", 32'(active), 32'd0);
        chk("arst.cyc", 32'(cyc_cnt), 32'd0);
        en = 1'b0;
        width = 8'd3;
        dead  = 8'd1;
        #3;
        rstn = 1'b1;
        run_seq("arst.idle", 32'h0, 32'h0, 32'h0, 3);
        chk("arst.idle_active", 32'(active), 32'd0);
        en = 1'b1;
        run_seq("restart", 32'h07, 32'h70, 32'h80, 8);
        chk("restart.active", 32'(active), 32'd1);
        run_seq("restart.next", 32'h1, 32'h0, 32'h0, 1);
        chk("restart.cyc", 32'(cyc_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sc_phase_gen.md
# sc_phase_gen

Digital two-phase non-overlapping clock generator that produces the complementary switch controls `phi1`/`phi2` for the switched-capacitor converter stage. It sits directly upstream of the converter switches. It derives both phases from one master clock through a counter-driven state machine with programmable phase width and dead time. It also supports cycle-granular pulse skipping and a graceful stop.

## Interface
- `CNT_W`, 8: width of the `width`/`dead` configuration fields and the phase counter.
- `CYC_W`, 16: width of the completed-cycle counter.
- `clk`  in  1  master clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request; sampled in IDLE and at the end of each cycle.
- `skip`  in  1  skip request; sampled at cycle start. When set, that whole cycle runs with both phases held low.
- `width`  in  CNT_W  phase-high duration in `clk` cycles; 0 is treated as 1.
- `dead`  in  CNT_W  dead time between phases in `clk` cycles; 0 is treated as 1.
- `phi1`  out  1  phase-1 switch control (registered).
- `phi2`  out  1  phase-2 switch control (registered).
- `active`  out  1  high whenever the state is not IDLE.
- `cycle_done`  out  1  one-cycle pulse during the last cycle of DEAD2.
- `cyc_cnt`  out  CYC_W  count of completed cycles; includes skipped cycles and wraps modulo 2^CYC_W.

## Operation
- States: IDLE, PH1, DEAD1, PH2, DEAD2.
- IDLE -> PH1 on the first edge with `en`=1. On that edge, `width`, `dead` and `skip` are latched into shadow registers as W, D and S, with 0 clamped to 1.
- Each phase lasts a fixed number of cycles, then hands over:
  - PH1 lasts W cycles, then DEAD1.
  - DEAD1 lasts D cycles, then PH2.
  - PH2 lasts W cycles, then DEAD2.
  - DEAD2 lasts D cycles, then the cycle ends.
- At the end of DEAD2:
  - if `en`=1: go to PH1 and re-latch W/D/S.
  - if `en`=0: go to IDLE.
- Changes to `width`/`dead`/`skip` mid-cycle have no effect until the next latch point.
- Output decode:
  - `phi1` = (state==PH1) & ~S.
  - `phi2` = (state==PH2) & ~S.
  - `phi1` and `phi2` are never high in the same cycle.
  - At least one dead cycle separates each falling phase from the next rising phase.
- Deasserting `en` mid-cycle never truncates a phase. The current cycle always completes through DEAD2.
- `cyc_cnt` increments by 1 on the edge that leaves DEAD2.
- Counter arithmetic:
  - phase counter is CNT_W bits, loaded with the duration minus 1, counting down to 0.
  - the maximum duration per state is 2^CNT_W - 1.

## Timing
- Reset (async assert): all outputs 0, state IDLE, shadow registers 0, `cyc_cnt` 0. Asserting reset mid-phase drops `phi1`/`phi2` immediately, without waiting for a clock edge.
- Reset release: no output change until the first edge with `en`=1.
- Start latency: `en` high before edge k means `phi1` is high from edge k and `active` is high from edge k.
- Period is 2·(W+D) clocks. The `phi1` rising edge recurs every 2·(W+D) clocks while `en` stays high.
- `cycle_done` is high for exactly the final clock of DEAD2. `cyc_cnt` updates on the following edge.
- `en` low during the last DEAD2 cycle: the next state is IDLE and `active` falls on that edge.
- `en` toggled low then high again before the end of DEAD2: no effect, back-to-back cycles continue.

## Test plan
- Basic, `width`=3, `dead`=1, `en` held high: `phi1` is high for 3 clocks, low 1, then `phi2` high 3, low 1. Period is 8 clocks, phases never overlap, and `cyc_cnt` reaches 4 after 32 clocks.
- Clamp, `width`=0, `dead`=0: behaves as W=1, D=1, giving a period of 4 clocks. `phi1` and `phi2` are never adjacent without a low cycle between them.
- Mid-cycle change, switching from W=3/D=1 to W=5/D=2 during PH2: the current cycle completes with 3/1. The next cycle runs 5/2 with a period of 14.
- Stop, `en` dropped during PH1: PH1, DEAD1, PH2 and DEAD2 all complete at full length. Then `active`=0, both phases stay 0, and `cyc_cnt` increments exactly once.
- Skip, `skip`=1 for one cycle start with `en` held high: `phi1`/`phi2` stay 0 for that full 2·(W+D) window. `cycle_done` still pulses, `cyc_cnt` increments, and the following cycle runs normally.
- Async reset, `rstn` pulled low between clock edges while `phi1`=1: `phi1` falls immediately. After release, outputs stay 0 until `en` is seen high, and the restart follows the start-latency rule.
